// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring radix-2 integer divider (DIV/DIVU)
// One quotient bit per cycle on operand magnitudes; signs are applied at completion.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             div_start,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] div_opr1,
   input  logic [WIDTH-1:0] div_opr2,
   input  logic             div_cancel,
   output logic             div_busy,
   output logic             div_done,
   output logic [WIDTH-1:0] div_quot,
   output logic [WIDTH-1:0] div_rem
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;     // partial remainder
   logic [WIDTH-1:0] quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] opr1_q, opr1_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dvz_q, dvz_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;

   logic             sgn1, sgn2;
   logic [WIDTH:0]   trial;
   logic             ge;
   logic [WIDTH-1:0] diff;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         opr1_q  <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dvz_q   <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         opr1_q  <= opr1_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dvz_q   <= dvz_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      opr1_d  = opr1_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dvz_d   = dvz_q;
      quot_d  = quot_q;
      rem_d   = rem_q;

      sgn1  = div_signed & div_opr1[WIDTH-1];
      sgn2  = div_signed & div_opr2[WIDTH-1];
      // Trial subtraction: the true difference is always below the divisor, so WIDTH bits suffice.
      trial = {acc_q, quo_q[WIDTH-1]};
      ge    = (trial >= {1'b0, dvsr_q});
      diff  = trial[WIDTH-1:0] - dvsr_q;

      case (state_q)
         S_IDLE: begin
            if (div_start && !div_cancel) begin
               state_d = S_CALC;
               cnt_d   = '0;
               acc_d   = '0;
               quo_d   = sgn1 ? (-div_opr1) : div_opr1;
               dvsr_d  = sgn2 ? (-div_opr2) : div_opr2;
               opr1_d  = div_opr1;
               qneg_d  = sgn1 ^ sgn2;
               rneg_d  = sgn1;
               dvz_d   = (div_opr2 == '0);
            end
         end
         S_CALC: begin
            if (div_cancel) begin
               state_d = S_IDLE;
            end else if (cnt_q == CW'(WIDTH)) begin
               state_d = S_DONE;
               // Divide-by-zero bypasses sign fix-up: all-ones quotient, raw dividend remainder.
               quot_d  = dvz_q ? '1 : (qneg_q ? (-quo_q) : quo_q);
               rem_d   = dvz_q ? opr1_q : (rneg_q ? (-acc_q) : acc_q);
            end else begin
               acc_d = ge ? diff : trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], ge};
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign div_busy = (state_q != S_IDLE);
   assign div_done = (state_q == S_DONE);
   assign div_quot = quot_q;
   assign div_rem  = rem_q;

endmodule
